// File: rtl/teclas_pkg.sv
// Shared key codes and scanner state encoding for the stopwatch/calculator slice.
package teclas_pkg;

  localparam int unsigned KEY_W = 5;

  localparam logic [KEY_W-1:0] T_A    = 5'd10;
  localparam logic [KEY_W-1:0] T_B    = 5'd11;
  localparam logic [KEY_W-1:0] T_C    = 5'd12;
  localparam logic [KEY_W-1:0] T_D    = 5'd13;
  localparam logic [KEY_W-1:0] T_ASTE = 5'd14;
  localparam logic [KEY_W-1:0] T_HASH = 5'd15;
  localparam logic [KEY_W-1:0] T_NULL = 5'd16;

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } kp_state_e;

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer; resets to all ones (idle level of pulled-up rows).
module keypad_sync #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;

  // Next values: shift the raw input through two stages.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchronizer stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
module keypad_scanner
  import teclas_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 3,
  parameter int unsigned DEB_CYC    = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       rows_n,
  output logic [3:0]       cols_n,
  output logic [KEY_W-1:0] key,
  output logic             key_pulse
);

  localparam int unsigned CNT_W = $clog2(DEB_CYC + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYC);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  // Key code for a (row, col) position of the matrix.
  function automatic logic [KEY_W-1:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [KEY_W-1:0] k;
    case ({r, c})
      4'h0: k = 5'd1;   4'h1: k = 5'd2;  4'h2: k = 5'd3;   4'h3: k = T_A;
      4'h4: k = 5'd4;   4'h5: k = 5'd5;  4'h6: k = 5'd6;   4'h7: k = T_B;
      4'h8: k = 5'd7;   4'h9: k = 5'd8;  4'hA: k = 5'd9;   4'hB: k = T_C;
      4'hC: k = T_ASTE; 4'hD: k = 5'd0;  4'hE: k = T_HASH; default: k = T_D;
    endcase
    return k;
  endfunction

  // Lowest-index row that reads low.
  function automatic logic [1:0] low_row(input logic [3:0] r_n);
    logic [1:0] r;
    if (!r_n[0])      r = 2'd0;
    else if (!r_n[1]) r = 2'd1;
    else if (!r_n[2]) r = 2'd2;
    else              r = 2'd3;
    return r;
  endfunction

  logic [3:0]       rs;
  kp_state_e        state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_pulse_q, key_pulse_d;
  logic [3:0]       cols_n_q, cols_n_d;
  logic [CNT_W-1:0] cnt_inc;

  keypad_sync #(.W(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rows_n),
    .q     (rs)
  );

  // Scan / debounce next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    set_d       = set_q;
    key_d       = key_q;
    key_pulse_d = 1'b0;
    cnt_inc     = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      ST_SCAN: begin
        if (set_q == SET_LAST) begin
          set_d = '0;
          if (&rs) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d   = low_row(rs);
            cnt_d   = CNT_W'(1);
            state_d = ST_DEB_PRESS;
          end
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      ST_DEB_PRESS: begin
        if (!rs[row_q]) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_MAX) begin
            cnt_d       = '0;
            key_d       = key_code(row_q, col_q);
            key_pulse_d = 1'b1;
            state_d     = ST_HELD;
          end
        end else begin
          cnt_d   = '0;
          set_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_HELD: begin
        if (rs[row_q]) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_DEB_REL;
        end
      end
      ST_DEB_REL: begin
        if (rs[row_q]) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_MAX) begin
            cnt_d   = '0;
            set_d   = '0;
            key_d   = T_NULL;
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end
        end else begin
          cnt_d   = '0;
          state_d = ST_HELD;
        end
      end
      default: state_d = ST_SCAN;
    endcase

    cols_n_d = ~(4'b0001 << col_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      col_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      set_q       <= '0;
      key_q       <= T_NULL;
      key_pulse_q <= 1'b0;
      cols_n_q    <= 4'b1110;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      set_q       <= set_d;
      key_q       <= key_d;
      key_pulse_q <= key_pulse_d;
      cols_n_q    <= cols_n_d;
    end
  end

  assign cols_n    = cols_n_q;
  assign key       = key_q;
  assign key_pulse = key_pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;
  import teclas_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic [4:0] key;
  logic       key_pulse;

  logic [15:0] pressed;   // bit r*4+c = key at (row r, col c) closed
  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  int bad_pulse = 0;
  int direct_chg = 0;
  logic [4:0] prev_key = 5'd16;

  keypad_scanner #(.SETTLE_CYC(3), .DEB_CYC(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rows_n    (rows_n),
    .cols_n    (cols_n),
    .key       (key),
    .key_pulse (key_pulse)
  );

  always #5 clk = ~clk;

  // Matrix model: a closed key pulls its row low while its column is driven low.
  always_comb begin
    rows_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
  end

  // Pulse bookkeeping and code-to-code transition watch.
  always @(negedge clk) begin
    if (key_pulse) pulse_cnt <= pulse_cnt + 1;
    if (key_pulse && (key == prev_key || key == 5'd16)) bad_pulse <= bad_pulse + 1;
    if (prev_key != 5'd16 && key != 5'd16 && key != prev_key) direct_chg <= direct_chg + 1;
    prev_key <= key;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_key(input logic [4:0] code, input int budget, output int n);
    n = 0;
    while (key !== code && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int p0;
  int bad;
  logic [3:0] exp_cols;

  initial begin
    rst_n   = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    check("rst_cols", 32'(cols_n), 32'(4'b1110));
    check("rst_key", 32'(key), 32'd16);
    check("rst_pulse", 32'(key_pulse), 32'd0);
    rst_n = 1'b1;

    // Idle rotation: column k/3 driven at the k-th cycle after reset release.
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      exp_cols = ~(4'b0001 << ((k / 3) % 4));
      check("idle_cols", 32'(cols_n), 32'(exp_cols));
    end
    repeat (76) @(negedge clk);
    check("idle_key", 32'(key), 32'd16);
    check("idle_pulses", 32'(pulse_cnt), 32'd0);

    // Key "5": row1/col1.
    p0 = pulse_cnt;
    pressed[5] = 1'b1;
    wait_key(5'd5, 40, n);
    check("k5_key", 32'(key), 32'd5);
    check("k5_pulse_at_key", 32'(key_pulse), 32'd1);
    check("k5_press_latency_in_22_34", 32'(n >= 22 && n <= 34), 32'd1);
    @(negedge clk);
    check("k5_pulse_one_cycle", 32'(key_pulse), 32'd0);
    repeat (40 - n - 1) @(negedge clk);
    pressed = '0;
    wait_key(5'd16, 40, n);
    check("k5_release_key", 32'(key), 32'd16);
    check("k5_release_latency", 32'(n), 32'd22);
    repeat (2) @(negedge clk);
    check("k5_pulse_count", 32'(pulse_cnt - p0), 32'd1);

    // Key "#": row3/col2 with 5-cycle chatter.
    p0 = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      pressed[14] = 1'b1;
      repeat (5) @(negedge clk);
      pressed[14] = 1'b0;
      repeat (5) @(negedge clk);
    end
    check("hash_chatter_key", 32'(key), 32'd16);
    check("hash_chatter_pulses", 32'(pulse_cnt - p0), 32'd0);
    pressed[14] = 1'b1;
    wait_key(5'd15, 40, n);
    check("hash_key", 32'(key), 32'd15);
    check("hash_latency_in_22_34", 32'(n >= 22 && n <= 34), 32'd1);
    repeat (5) @(negedge clk);
    pressed = '0;
    wait_key(5'd16, 40, n);
    check("hash_release_latency", 32'(n), 32'd22);
    repeat (2) @(negedge clk);
    check("hash_pulse_count", 32'(pulse_cnt - p0), 32'd1);

    // Key "D" held, "1" added: first key wins; after D release, 1 takes over.
    pressed[15] = 1'b1;
    wait_key(5'd13, 40, n);
    check("d_key", 32'(key), 32'd13);
    repeat (2) @(negedge clk);
    p0 = pulse_cnt;
    pressed[0] = 1'b1;
    repeat (30) @(negedge clk);
    check("d_with_1_key", 32'(key), 32'd13);
    check("d_with_1_pulses", 32'(pulse_cnt - p0), 32'd0);
    pressed[15] = 1'b0;
    wait_key(5'd16, 40, n);
    check("d_release_key", 32'(key), 32'd16);
    check("d_release_latency", 32'(n), 32'd22);
    wait_key(5'd1, 40, n);
    check("one_key", 32'(key), 32'd1);
    check("one_latency", 32'(n), 32'd22);
    check("one_pulse_at_key", 32'(key_pulse), 32'd1);
    repeat (2) @(negedge clk);
    check("one_pulse_count", 32'(pulse_cnt - p0), 32'd1);
    pressed = '0;
    wait_key(5'd16, 40, n);
    check("one_release_latency", 32'(n), 32'd22);

    // Key "*": 8-cycle open glitch while held.
    pressed[12] = 1'b1;
    wait_key(5'd14, 40, n);
    check("ast_key", 32'(key), 32'd14);
    repeat (2) @(negedge clk);
    p0 = pulse_cnt;
    repeat (5) @(negedge clk);
    bad = 0;
    pressed[12] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (key !== 5'd14) bad++;
    end
    pressed[12] = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (key !== 5'd14) bad++;
    end
    check("ast_glitch_key_stable", 32'(bad), 32'd0);
    check("ast_glitch_pulses", 32'(pulse_cnt - p0), 32'd0);
    pressed = '0;
    wait_key(5'd16, 40, n);
    check("ast_release_latency", 32'(n), 32'd22);

    // Key "7": reset while held, then re-detect.
    pressed[8] = 1'b1;
    wait_key(5'd7, 40, n);
    check("k7_key", 32'(key), 32'd7);
    repeat (3) @(negedge clk);
    p0 = pulse_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("k7_async_rst_key", 32'(key), 32'd16);
    check("k7_async_rst_cols", 32'(cols_n), 32'(4'b1110));
    check("k7_async_rst_pulse", 32'(key_pulse), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_key(5'd7, 40, n);
    check("k7_redetect_key", 32'(key), 32'd7);
    check("k7_redetect_latency", 32'(n), 32'd22);
    check("k7_redetect_pulse", 32'(key_pulse), 32'd1);
    repeat (2) @(negedge clk);
    check("k7_pulse_count", 32'(pulse_cnt - p0), 32'd1);
    pressed = '0;
    wait_key(5'd16, 40, n);
    check("k7_release_key", 32'(key), 32'd16);

    check("no_code_to_code", 32'(direct_chg), 32'd0);
    check("no_stray_pulse", 32'(bad_pulse), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
